// File: rtl/sw_pkg.sv
// Shared codes for the Smith-Waterman/Gotoh datapath: edit ops, direction-word
// layout and traceback state encodings. The PE array packs its outputs with these too.
package sw_pkg;

  localparam logic [1:0] OP_M = 2'd0;
  localparam logic [1:0] OP_I = 2'd1;
  localparam logic [1:0] OP_D = 2'd2;

  localparam logic [1:0] DIR_DIAG = 2'd0;
  localparam logic [1:0] DIR_TOP  = 2'd1;
  localparam logic [1:0] DIR_LEFT = 2'd2;

  // Direction word: [3:2] v_dir, [1] i_dir (I opened from V), [0] d_dir (D opened from V)
  localparam int DW_VDIR_HI = 3;
  localparam int DW_VDIR_LO = 2;
  localparam int DW_IDIR    = 1;
  localparam int DW_DDIR    = 0;

  typedef enum logic [1:0] {MS_V, MS_I, MS_D} mstate_t;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_STEP, S_EMIT, S_FINISH
  } state_t;

endpackage

// File: rtl/sw_traceback_if.sv
// Edit-op stream between the traceback walker and the alignment formatter.
interface sw_traceback_if;
  logic       op_valid;
  logic [1:0] op;
  logic       op_last;
  logic       op_ready;

  modport master (output op_valid, op, op_last, input  op_ready);
  modport slave  (input  op_valid, op, op_last, output op_ready);
endinterface

// File: rtl/sw_traceback.sv
// Gotoh affine-gap traceback: walks the direction RAM from an end cell back to
// the matrix boundary and streams the alignment as M/I/D edit ops.
module sw_traceback
  import sw_pkg::*;
#(
  parameter int ROW_W = 10,
  parameter int COL_W = 10,
  parameter int LEN_W = 11
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [ROW_W-1:0] i_end_row,
  input  logic [COL_W-1:0] i_end_col,
  output logic             o_mem_rd,
  output logic [ROW_W-1:0] o_mem_row,
  output logic [COL_W-1:0] o_mem_col,
  input  logic [3:0]       i_mem_data,
  sw_traceback_if.master   op_if,
  output logic             o_busy,
  output logic             o_done,
  output logic [LEN_W-1:0] o_len
);

  state_t           r_state, w_state_nxt;
  mstate_t          r_ms;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic [3:0]       r_dir;
  logic [1:0]       r_op;
  logic             r_last;
  logic [LEN_W-1:0] r_cnt;

  logic [1:0] w_vdir;
  logic       w_hs;
  logic       w_zero_start;

  assign w_vdir       = r_dir[DW_VDIR_HI:DW_VDIR_LO];
  assign w_hs         = (r_state == S_EMIT) && op_if.op_ready;
  assign w_zero_start = (i_end_row == '0) || (i_end_col == '0);

  // NOTE: state and data registers use non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // NOTE: default assigned first so no path through the case leaves
  // w_state_nxt unassigned, which would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (i_start) w_state_nxt = w_zero_start ? S_FINISH : S_READ;
      S_READ:   w_state_nxt = S_WAIT;
      S_WAIT:   w_state_nxt = S_STEP;
      S_STEP: begin
        // A V-state cell pointing up/left only switches matrix, costing one extra STEP.
        if (r_ms == MS_V && (w_vdir == DIR_TOP || w_vdir == DIR_LEFT))
          w_state_nxt = S_STEP;
        else
          w_state_nxt = S_EMIT;
      end
      S_EMIT:   if (op_if.op_ready) w_state_nxt = r_last ? S_FINISH : S_READ;
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ms   <= MS_V;
      r_row  <= '0;
      r_col  <= '0;
      r_dir  <= '0;
      r_op   <= OP_M;
      r_last <= 1'b0;
      r_cnt  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (i_start) begin
          r_row <= i_end_row;
          r_col <= i_end_col;
          r_ms  <= MS_V;
          r_cnt <= '0;
        end
        S_WAIT: r_dir <= i_mem_data;
        S_STEP: begin
          unique case (r_ms)
            MS_I: begin
              r_op   <= OP_I;
              r_last <= (r_col == COL_W'(1));
            end
            MS_D: begin
              r_op   <= OP_D;
              r_last <= (r_row == ROW_W'(1));
            end
            default: begin
              if (w_vdir == DIR_TOP)       r_ms <= MS_D;
              else if (w_vdir == DIR_LEFT) r_ms <= MS_I;
              else begin
                r_op   <= OP_M;
                r_last <= (r_row == ROW_W'(1)) || (r_col == COL_W'(1));
              end
            end
          endcase
        end
        S_EMIT: if (w_hs) begin
          // Gap-close bits of the current cell decide whether the next cell is read in V.
          unique case (r_op)
            OP_I: begin
              r_col <= r_col - COL_W'(1);
              r_ms  <= r_dir[DW_IDIR] ? MS_V : MS_I;
            end
            OP_D: begin
              r_row <= r_row - ROW_W'(1);
              r_ms  <= r_dir[DW_DDIR] ? MS_V : MS_D;
            end
            default: begin
              r_row <= r_row - ROW_W'(1);
              r_col <= r_col - COL_W'(1);
              r_ms  <= MS_V;
            end
          endcase
          if (r_cnt != '1) r_cnt <= r_cnt + LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_mem_rd       = (r_state == S_READ);
  assign o_mem_row      = r_row;
  assign o_mem_col      = r_col;
  assign op_if.op_valid = (r_state == S_EMIT);
  assign op_if.op       = r_op;
  assign op_if.op_last  = (r_state == S_EMIT) && r_last;
  assign o_busy         = (r_state == S_READ) || (r_state == S_WAIT) ||
                          (r_state == S_STEP) || (r_state == S_EMIT);
  assign o_done         = (r_state == S_FINISH);
  assign o_len          = r_cnt;

endmodule

// File: tb/tb_sw_traceback.sv
// Bench for sw_traceback: table of tracebacks over a small direction-memory model,
// with op/read scoreboards, a backpressure stall and a mid-traceback reset.
module tb_sw_traceback;
  import sw_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_start;
  logic [9:0] i_end_row, i_end_col;
  logic       o_mem_rd;
  logic [9:0] o_mem_row, o_mem_col;
  logic [3:0] i_mem_data;
  logic       o_busy, o_done;
  logic [10:0] o_len;

  sw_traceback_if op_if ();

  sw_traceback #(.ROW_W(10), .COL_W(10), .LEN_W(11)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start),
    .i_end_row(i_end_row), .i_end_col(i_end_col),
    .o_mem_rd(o_mem_rd), .o_mem_row(o_mem_row), .o_mem_col(o_mem_col),
    .i_mem_data(i_mem_data), .op_if(op_if),
    .o_busy(o_busy), .o_done(o_done), .o_len(o_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  er, ec;
    int          n_ops;
    logic [15:0] ops;    // op k at [2k+:2]
    logic [63:0] rds;    // read k at [8k+:8] as {row[3:0], col[3:0]}
    int          stall_at;
    bit          poke;
    int          cyc;
  } vec_t;

  typedef struct packed { logic [1:0] op; logic last; } exp_op_t;

  exp_op_t     op_q[$];
  logic [19:0] rd_q[$];
  logic [3:0]  mem [0:15][0:15];
  int          n_checks = 0;
  int          n_err    = 0;
  int          n_ops_seen;
  int          stall_at;
  int          stall_cnt;
  logic [1:0]  held_op;
  vec_t        vt[6];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(int er, int ec, int n, logic [15:0] ops,
                              logic [63:0] rds, int st, bit poke, int cyc);
    vec_t v;
    v.er = 10'(er); v.ec = 10'(ec); v.n_ops = n; v.ops = ops; v.rds = rds;
    v.stall_at = st; v.poke = poke; v.cyc = cyc;
    return v;
  endfunction

  // Memory responder: data valid exactly one cycle after the read strobe.
  always @(posedge clk)
    if (o_mem_rd) i_mem_data <= mem[o_mem_row[3:0]][o_mem_col[3:0]];

  always @(negedge clk) begin
    if (o_mem_rd) begin
      if (rd_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
      else check("rd_addr", {12'd0, o_mem_row, o_mem_col}, {12'd0, rd_q.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (op_if.op_valid) begin
      if (n_ops_seen == stall_at && stall_cnt < 5) begin
        if (stall_cnt > 0) check("op_stable", {30'd0, op_if.op}, {30'd0, held_op});
        check("rd_in_stall", {31'd0, o_mem_rd}, 32'd0);
        held_op = op_if.op;
        stall_cnt++;
        op_if.op_ready = 1'b0;
      end else begin
        exp_op_t e;
        op_if.op_ready = 1'b1;
        if (op_q.size() == 0) check("op_unexpected", 32'd1, 32'd0);
        else begin
          e = op_q.pop_front();
          check("op_code", {30'd0, op_if.op}, {30'd0, e.op});
          check("op_last", {31'd0, op_if.op_last}, {31'd0, e.last});
        end
        n_ops_seen++;
      end
    end else op_if.op_ready = 1'b1;
  end

  task automatic load_mem(int idx);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) mem[r][c] = 4'b0000;
    if (idx == 2) begin mem[2][4] = 4'b1000; mem[2][3] = 4'b0010; end
    if (idx == 3) mem[3][1] = 4'b0101;
  endtask

  task automatic push_expect(vec_t v);
    for (int k = 0; k < v.n_ops; k++) begin
      exp_op_t     e;
      logic [9:0]  r, c;
      e.op = v.ops[2*k +: 2];
      e.last = (k == v.n_ops - 1);
      op_q.push_back(e);
      r = 10'(v.rds[8*k+4 +: 4]);
      c = 10'(v.rds[8*k +: 4]);
      rd_q.push_back({r, c});
    end
    n_ops_seen = 0; stall_cnt = 0; stall_at = v.stall_at;
  endtask

  task automatic run_vec(int idx);
    vec_t v;
    int   cyc;
    v = vt[idx];
    load_mem(idx);
    push_expect(v);
    @(negedge clk);
    i_end_row = v.er; i_end_col = v.ec; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    cyc = 1;
    while (!o_done && cyc < 400) begin
      if (v.n_ops > 0 && cyc == 1) check("busy_running", {31'd0, o_busy}, 32'd1);
      if (v.poke && cyc == 3) begin i_end_row = 10'd7; i_end_col = 10'd7; end
      i_start = v.poke && (cyc == 3);
      @(negedge clk);
      cyc++;
    end
    i_start = 1'b0;
    if (!o_done) check("done_timeout", 32'd0, 32'd1);
    else begin
      check("cycles", 32'(cyc), 32'(v.cyc));
      check("len", {21'd0, o_len}, 32'(v.n_ops));
      check("busy_at_done", {31'd0, o_busy}, 32'd0);
    end
    check("ops_left", 32'(op_q.size()), 32'd0);
    check("rds_left", 32'(rd_q.size()), 32'd0);
    @(negedge clk);
    check("done_pulse", {31'd0, o_done}, 32'd0);
    check("len_hold", {21'd0, o_len}, 32'(v.n_ops));
  endtask

  initial begin
    stall_at = -1; stall_cnt = 0; n_ops_seen = 0;
    op_if.op_ready = 1'b1;
    i_start = 1'b0; i_end_row = '0; i_end_col = '0; i_mem_data = '0;
    load_mem(0);

    vt[0] = mk(1, 1, 1, 16'h0000, {56'd0, 8'h11}, -1, 1'b0, 5);
    vt[1] = mk(3, 3, 3, {10'd0, OP_M, OP_M, OP_M}, {40'd0, 8'h11, 8'h22, 8'h33}, -1, 1'b0, 13);
    vt[2] = mk(2, 4, 4, {8'd0, OP_M, OP_M, OP_I, OP_I},
               {32'd0, 8'h11, 8'h22, 8'h23, 8'h24}, -1, 1'b0, 18);
    vt[3] = mk(3, 1, 2, {12'd0, OP_M, OP_D}, {48'd0, 8'h21, 8'h31}, -1, 1'b0, 10);
    vt[4] = mk(3, 3, 3, {10'd0, OP_M, OP_M, OP_M}, {40'd0, 8'h11, 8'h22, 8'h33}, 1, 1'b1, 18);
    vt[5] = mk(0, 5, 0, 16'h0000, 64'd0, -1, 1'b0, 1);

    rst_n = 1'b0;
    #12;
    check("rst_busy",   {31'd0, o_busy}, 32'd0);
    check("rst_done",   {31'd0, o_done}, 32'd0);
    check("rst_mem_rd", {31'd0, o_mem_rd}, 32'd0);
    check("rst_valid",  {31'd0, op_if.op_valid}, 32'd0);
    check("rst_outs",   {o_mem_row, o_mem_col, o_len, op_if.op_last},
                        {10'd0, 10'd0, 11'd0, 1'b0});
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(i);

    // Abort with reset while the second op of a 3x3 diagonal walk is presented.
    load_mem(1);
    push_expect(vt[1]);
    @(negedge clk);
    i_end_row = 10'd3; i_end_col = 10'd3; i_start = 1'b1;
    @(negedge clk) i_start = 1'b0;
    begin
      int  n;
      bit  hit;
      n = 0; hit = 1'b0;
      while (!hit && n < 100) begin
        @(posedge clk); #1;
        hit = op_if.op_valid && (n_ops_seen == 1);
        n++;
      end
      check("abort_reached", {31'd0, hit}, 32'd1);
    end
    #1 rst_n = 1'b0;
    #1;
    check("abort_valid", {31'd0, op_if.op_valid}, 32'd0);
    check("abort_busy",  {31'd0, o_busy}, 32'd0);
    check("abort_outs",  {o_mem_row, o_mem_col, o_len, op_if.op_last, o_mem_rd},
                         {10'd0, 10'd0, 11'd0, 1'b0, 1'b0});
    op_q.delete(); rd_q.delete();
    stall_at = -1;
    for (int k = 0; k < 3; k++) @(negedge clk) check("abort_no_done", {31'd0, o_done}, 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) @(negedge clk) check("idle_no_done", {31'd0, o_done}, 32'd0);
    run_vec(1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
